wb_rr_intercon: RTL and testbench

Parametrised shared-bus Wishbone interconnect for the LM32 SoC, replacing the fixed 8×8 connection bus in board top levels. It connects NUM_M masters to NUM_S slaves with round-robin arbitration, base/mask address decoding, error responses for unmapped addresses, and an optional bus-timeout watchdog. Board `system` modules instantiate it between `lm32_cpu` (I/D ports) and peripherals (bram, sram, uart, timer, gpio).

---
 rtl/wb_rr_intercon_if.sv | 62 ++++++
 rtl/wb_rr_intercon.sv | 256 +++++++++++++++++++++++++
 tb/tb_wb_rr_intercon.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/wb_rr_intercon_if.sv
// wb_rr_intercon_if
// Bundle of every Wishbone signal that passes through the shared-bus interconnect.
// Signal names carry the interconnect's own _i/_o direction so that board tops and
// the interconnect body refer to one set of names.
//
// Parameters:
//   NUM_M  number of masters
//   NUM_S  number of slaves
//
// Modports:
//   slave   view used by wb_rr_intercon (sinks master requests and slave responses)
//   master  view used by the surrounding system (drives requests, models the slaves)
//
// Signals:
//   m_adr_i/m_dat_i/m_sel_i/m_we_i/m_cyc_i/m_stb_i  packed per-master request fields
//   m_dat_o/m_ack_o/m_err_o/m_rty_o                 read data broadcast, per-master responses
//   s_adr_o/s_dat_o/s_sel_o/s_we_o                  shared slave request fields
//   s_cyc_o/s_stb_o                                 per-slave cycle and strobe
//   s_dat_i/s_ack_i/s_err_i/s_rty_i                 per-slave read data and responses
//   grant_o                                         one-hot current grant (probe)
interface wb_rr_intercon_if #(
  parameter int NUM_M = 2,
  parameter int NUM_S = 8
);
  logic [NUM_M*32-1:0] m_adr_i;
  logic [NUM_M*32-1:0] m_dat_i;
  logic [NUM_M*4-1:0]  m_sel_i;
  logic [NUM_M-1:0]    m_we_i;
  logic [NUM_M-1:0]    m_cyc_i;
  logic [NUM_M-1:0]    m_stb_i;
  logic [31:0]         m_dat_o;
  logic [NUM_M-1:0]    m_ack_o;
  logic [NUM_M-1:0]    m_err_o;
  logic [NUM_M-1:0]    m_rty_o;
  logic [31:0]         s_adr_o;
  logic [31:0]         s_dat_o;
  logic [3:0]          s_sel_o;
  logic                s_we_o;
  logic [NUM_S-1:0]    s_cyc_o;
  logic [NUM_S-1:0]    s_stb_o;
  logic [NUM_S*32-1:0] s_dat_i;
  logic [NUM_S-1:0]    s_ack_i;
  logic [NUM_S-1:0]    s_err_i;
  logic [NUM_S-1:0]    s_rty_i;
  logic [NUM_M-1:0]    grant_o;

  modport slave (
    input  m_adr_i, m_dat_i, m_sel_i, m_we_i, m_cyc_i, m_stb_i,
    output m_dat_o, m_ack_o, m_err_o, m_rty_o,
    output s_adr_o, s_dat_o, s_sel_o, s_we_o, s_cyc_o, s_stb_o,
    input  s_dat_i, s_ack_i, s_err_i, s_rty_i,
    output grant_o
  );

  modport master (
    output m_adr_i, m_dat_i, m_sel_i, m_we_i, m_cyc_i, m_stb_i,
    input  m_dat_o, m_ack_o, m_err_o, m_rty_o,
    input  s_adr_o, s_dat_o, s_sel_o, s_we_o, s_cyc_o, s_stb_o,
    output s_dat_i, s_ack_i, s_err_i, s_rty_i,
    input  grant_o
  );
endinterface

// File: rtl/wb_rr_intercon.sv
// wb_rr_intercon
// Shared-bus Wishbone interconnect: NUM_M masters, NUM_S slaves, round-robin
// arbitration, base/mask address decode, error response on unmapped addresses.
//
// Optional feature: define WB_RR_INTERCON_WATCHDOG_EN to add a bus-timeout
// watchdog that returns an error to the granted master after TIMEOUT stalled
// cycles. Without it a mapped slave that never answers stalls the bus.
//
// Parameters:
//   NUM_M    masters (1..8)
//   NUM_S    slaves (1..16)
//   S_BASE   packed slave base addresses, slave k in [32k+31:32k]
//   S_MASK   packed slave decode masks, slave k in [32k+31:32k]
//   TIMEOUT  watchdog limit in cycles (1..65535)
//
// Ports:
//   clk    system clock, rising edge
//   rst_n  asynchronous active-low reset
//   bus    wb_rr_intercon_if.slave, all master and slave Wishbone signals
//
// Request and response paths are combinational behind the registered grant;
// only the grant, the round-robin pointer and the error pulse are state.
module wb_rr_intercon #(
  parameter int                  NUM_M   = 2,
  parameter int                  NUM_S   = 8,
  parameter logic [NUM_S*32-1:0] S_BASE  = {NUM_S{32'h0000_0000}},
  parameter logic [NUM_S*32-1:0] S_MASK  = {NUM_S{32'hE000_0000}},
  parameter int                  TIMEOUT = 1023
) (
  input logic             clk,
  input logic             rst_n,
  wb_rr_intercon_if.slave bus
);

  localparam int MW = (NUM_M > 1) ? $clog2(NUM_M) : 1;

  typedef enum logic {
    IDLE  = 1'b0,
    OWNED = 1'b1
  } state_t;

  state_t           state_r;
  state_t           state_nxt_s;
  logic [NUM_M-1:0] grant_r;
  logic [NUM_M-1:0] grant_nxt_s;
  logic [MW-1:0]    last_r;
  logic [MW-1:0]    last_nxt_s;

  logic             rr_found_s;
  logic [MW-1:0]    rr_idx_s;
  logic [NUM_M-1:0] rr_oh_s;

  logic             gnt_cyc_s;
  logic             gnt_stb_s;
  logic [31:0]      adr_s;
  logic [31:0]      wdat_s;
  logic [3:0]       sel_s;
  logic             we_s;

  logic [NUM_S-1:0] hit_raw_s;
  logic [NUM_S-1:0] hit_oh_s;
  logic             any_hit_s;
  logic [NUM_S-1:0] dec_oh_s;

  logic [31:0]      rdat_s;
  logic             resp_ack_s;
  logic             resp_err_s;
  logic             resp_rty_s;

  logic             miss_s;
  logic             wd_fire_s;
  logic             err_r;

  // Round-robin search: first requester strictly after last_r, wrapping; last_r itself is tried last.
  always_comb begin
    rr_found_s = 1'b0;
    rr_idx_s   = {MW{1'b0}};
    for (int i = 1; i <= NUM_M; i++) begin
      logic [MW-1:0] cand;
      cand = MW'((int'(last_r) + i) % NUM_M);
      if (!rr_found_s && bus.m_cyc_i[cand]) begin
        rr_found_s = 1'b1;
        rr_idx_s   = cand;
      end else begin
        rr_found_s = rr_found_s;
      end
    end
  end

  // One-hot form of the round-robin winner.
  always_comb begin
    rr_oh_s = {NUM_M{1'b0}};
    for (int i = 0; i < NUM_M; i++) begin
      rr_oh_s[i] = (rr_idx_s == MW'(i));
    end
  end

  // Arbiter state, grant and pointer registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
      grant_r <= {NUM_M{1'b0}};
      last_r  <= MW'(NUM_M - 1);
    end else begin
      state_r <= state_nxt_s;
      grant_r <= grant_nxt_s;
      last_r  <= last_nxt_s;
    end
  end

  // Arbiter next state: hold while the owner keeps cyc, hand over in the same edge it drops.
  always_comb begin
    state_nxt_s = state_r;
    grant_nxt_s = grant_r;
    last_nxt_s  = last_r;
    case (state_r)
      IDLE: begin
        if (rr_found_s) begin
          state_nxt_s = OWNED;
          grant_nxt_s = rr_oh_s;
          last_nxt_s  = rr_idx_s;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      OWNED: begin
        if (gnt_cyc_s) begin
          state_nxt_s = OWNED;
        end else if (rr_found_s) begin
          // last_r is the owner, so the search naturally skips to the next requester.
          state_nxt_s = OWNED;
          grant_nxt_s = rr_oh_s;
          last_nxt_s  = rr_idx_s;
        end else begin
          state_nxt_s = IDLE;
          grant_nxt_s = {NUM_M{1'b0}};
        end
      end
      default: begin
        state_nxt_s = IDLE;
        grant_nxt_s = {NUM_M{1'b0}};
      end
    endcase
  end

  // Request mux: AND-OR of the granted master's fields, all zero when nobody is granted.
  always_comb begin
    gnt_cyc_s = 1'b0;
    gnt_stb_s = 1'b0;
    adr_s     = 32'h0000_0000;
    wdat_s    = 32'h0000_0000;
    sel_s     = 4'h0;
    we_s      = 1'b0;
    for (int i = 0; i < NUM_M; i++) begin
      if (grant_r[i]) begin
        gnt_cyc_s = gnt_cyc_s | bus.m_cyc_i[i];
        gnt_stb_s = gnt_stb_s | (bus.m_cyc_i[i] & bus.m_stb_i[i]);
        adr_s     = adr_s  | bus.m_adr_i[i*32 +: 32];
        wdat_s    = wdat_s | bus.m_dat_i[i*32 +: 32];
        sel_s     = sel_s  | bus.m_sel_i[i*4 +: 4];
        we_s      = we_s   | bus.m_we_i[i];
      end else begin
        gnt_cyc_s = gnt_cyc_s;
      end
    end
  end

  // Address compare against every slave window.
  always_comb begin
    hit_raw_s = {NUM_S{1'b0}};
    for (int k = 0; k < NUM_S; k++) begin
      hit_raw_s[k] = ((adr_s & S_MASK[k*32 +: 32]) == (S_BASE[k*32 +: 32] & S_MASK[k*32 +: 32]));
    end
  end

  // Priority select: on overlapping windows the lowest slave index wins.
  always_comb begin
    hit_oh_s  = {NUM_S{1'b0}};
    any_hit_s = 1'b0;
    for (int k = 0; k < NUM_S; k++) begin
      if (hit_raw_s[k] && !any_hit_s) begin
        hit_oh_s[k] = 1'b1;
        any_hit_s   = 1'b1;
      end else begin
        any_hit_s = any_hit_s;
      end
    end
  end

  // Decode is only live while the owner holds cyc; otherwise address 0 could select a slave.
  assign dec_oh_s = hit_oh_s & {NUM_S{gnt_cyc_s}};
  assign miss_s   = gnt_stb_s & ~any_hit_s;

  // Response mux from the selected slave.
  always_comb begin
    rdat_s = 32'h0000_0000;
    for (int k = 0; k < NUM_S; k++) begin
      if (dec_oh_s[k]) begin
        rdat_s = rdat_s | bus.s_dat_i[k*32 +: 32];
      end else begin
        rdat_s = rdat_s;
      end
    end
  end

  assign resp_ack_s = |(bus.s_ack_i & dec_oh_s);
  assign resp_err_s = |(bus.s_err_i & dec_oh_s);
  assign resp_rty_s = |(bus.s_rty_i & dec_oh_s);

`ifdef WB_RR_INTERCON_WATCHDOG_EN
  localparam logic [15:0] TIMEOUT_W = 16'(TIMEOUT);

  logic [15:0] wd_cnt_r;
  logic        wd_stall_s;

  // A mapped, strobed access that got no answer from its slave this cycle.
  assign wd_stall_s = gnt_stb_s & any_hit_s & ~(resp_ack_s | resp_err_s | resp_rty_s);
  assign wd_fire_s  = wd_stall_s & ((wd_cnt_r + 16'd1) == TIMEOUT_W);

  // Stall counter: counts stalled cycles, restarts on any response, idle strobe or a fired timeout.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wd_cnt_r <= 16'd0;
    end else if (!wd_stall_s || wd_fire_s) begin
      wd_cnt_r <= 16'd0;
    end else begin
      wd_cnt_r <= wd_cnt_r + 16'd1;
    end
  end
`else
  assign wd_fire_s = 1'b0;
`endif

  // Interconnect-generated error pulse; a held miss strobe re-arms only after the pulse has gone out.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_r <= 1'b0;
    end else begin
      err_r <= (miss_s & ~err_r) | wd_fire_s;
    end
  end

  assign bus.s_adr_o = adr_s;
  assign bus.s_dat_o = wdat_s;
  assign bus.s_sel_o = sel_s;
  assign bus.s_we_o  = we_s;
  assign bus.s_cyc_o = dec_oh_s;
  assign bus.s_stb_o = dec_oh_s & {NUM_S{gnt_stb_s}};

  assign bus.m_dat_o = rdat_s;
  assign bus.m_ack_o = grant_r & {NUM_M{resp_ack_s}};
  assign bus.m_err_o = grant_r & {NUM_M{resp_err_s | err_r}};
  assign bus.m_rty_o = grant_r & {NUM_M{resp_rty_s}};
  assign bus.grant_o = grant_r;

endmodule

// File: tb/tb_wb_rr_intercon.sv
// tb_wb_rr_intercon
// Directed bench for wb_rr_intercon with two masters and four slaves:
//   slave 0 0x8xxxxxxx, slave 1 0x9xxxxxxx (never answers), slave 2 0x0xxxxxxx (bram),
//   slave 3 0x0000xxxx (overlaps slave 2, must lose). 0xAxxxxxxx is unmapped.
// Inputs change on the falling edge, outputs are sampled on the falling edge.
module tb_wb_rr_intercon;

  localparam logic [127:0] SB = {32'h0000_0000, 32'h0000_0000, 32'h9000_0000, 32'h8000_0000};
  localparam logic [127:0] SM = {32'hFFFF_0000, 32'hF000_0000, 32'hF000_0000, 32'hF000_0000};

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   passes = 0;

  wb_rr_intercon_if #(.NUM_M(2), .NUM_S(4)) bus ();

  wb_rr_intercon #(
    .NUM_M(2), .NUM_S(4), .S_BASE(SB), .S_MASK(SM), .TIMEOUT(15)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  always #5 clk = ~clk;

  // Slave model: classic single-cycle ack one edge after strobe; slave 1 stays silent.
  logic [3:0] ack_r = 4'b0000;
  logic [3:0] resp_en = 4'b1101;
  always @(posedge clk) begin
    ack_r <= bus.s_cyc_o & bus.s_stb_o & resp_en & ~ack_r;
  end
  assign bus.s_ack_i = ack_r;
  assign bus.s_err_i = 4'b0000;
  assign bus.s_rty_i = 4'b0000;
  assign bus.s_dat_i = {32'hD000_0003, 32'hD000_0002, 32'hD000_0001, 32'hD000_0000};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic idle_all();
    bus.m_adr_i = 64'h0;
    bus.m_dat_i = 64'h0;
    bus.m_sel_i = 8'h0;
    bus.m_we_i  = 2'b00;
    bus.m_cyc_i = 2'b00;
    bus.m_stb_i = 2'b00;
  endtask

  initial begin
    int acks;
    int errs;
    int first;

    idle_all();
    @(negedge clk);
    check("rst_grant", 32'(bus.grant_o), 32'd0);
    check("rst_s_cyc", 32'(bus.s_cyc_o), 32'd0);
    check("rst_s_stb", 32'(bus.s_stb_o), 32'd0);
    check("rst_m_ack", 32'(bus.m_ack_o), 32'd0);
    check("rst_m_err", 32'(bus.m_err_o), 32'd0);
    check("rst_m_rty", 32'(bus.m_rty_o), 32'd0);
    check("rst_s_adr", bus.s_adr_o, 32'd0);
    check("rst_s_we",  32'(bus.s_we_o), 32'd0);
    rst_n = 1'b1;

    // Single master read from bram at 0x10; slave 3 overlaps but slave 2 must win.
    bus.m_adr_i = {32'h0, 32'h0000_0010};
    bus.m_cyc_i = 2'b01;
    bus.m_stb_i = 2'b01;
    @(negedge clk);
    check("rd_grant", 32'(bus.grant_o), 32'd1);
    check("rd_s_cyc", 32'(bus.s_cyc_o), 32'h4);
    check("rd_s_stb", 32'(bus.s_stb_o), 32'h4);
    check("rd_s_adr", bus.s_adr_o, 32'h10);
    check("rd_noack", 32'(bus.m_ack_o), 32'd0);
    @(negedge clk);
    check("rd_ack", 32'(bus.m_ack_o), 32'd1);
    check("rd_dat", bus.m_dat_o, 32'hD000_0002);
    idle_all();
    @(negedge clk);
    check("rd_idle_grant", 32'(bus.grant_o), 32'd0);
    check("rd_idle_ack", 32'(bus.m_ack_o), 32'd0);

    // Contention straight after reset: master 0 first, handover with no idle cycle.
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    bus.m_adr_i = {32'h0000_0010, 32'h0000_0010};
    bus.m_cyc_i = 2'b11;
    bus.m_stb_i = 2'b11;
    @(negedge clk);
    check("ct_grant0", 32'(bus.grant_o), 32'd1);
    @(negedge clk);
    check("ct_ack0", 32'(bus.m_ack_o), 32'd1);
    bus.m_cyc_i = 2'b10;
    bus.m_stb_i = 2'b10;
    @(negedge clk);
    check("ct_handover", 32'(bus.grant_o), 32'd2);
    check("ct_s_stb1", 32'(bus.s_stb_o), 32'h4);
    @(negedge clk);
    check("ct_ack1", 32'(bus.m_ack_o), 32'd2);
    bus.m_cyc_i = 2'b01;
    bus.m_stb_i = 2'b01;
    @(negedge clk);
    check("ct_back_to_0", 32'(bus.grant_o), 32'd1);
    @(negedge clk);
    check("ct_ack0b", 32'(bus.m_ack_o), 32'd1);
    idle_all();
    @(negedge clk);
    check("ct_idle", 32'(bus.grant_o), 32'd0);

    // Master 1 (next in turn) holds cyc over 4 strobes while master 0 waits.
    bus.m_adr_i = {32'h0000_0010, 32'h0000_0010};
    bus.m_cyc_i = 2'b11;
    bus.m_stb_i = 2'b11;
    acks = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("hold_grant1", 32'(bus.grant_o), 32'd2);
      check("hold_noack0", 32'(bus.m_ack_o[0]), 32'd0);
      if (bus.m_ack_o[1]) acks++;
    end
    check("hold_acks", 32'(acks), 32'd4);
    bus.m_cyc_i = 2'b01;
    bus.m_stb_i = 2'b01;
    @(negedge clk);
    check("hold_release", 32'(bus.grant_o), 32'd1);
    @(negedge clk);
    check("hold_ack0", 32'(bus.m_ack_o), 32'd1);
    idle_all();
    @(negedge clk);

    // Unmapped address: error the cycle after the strobe, re-armed every other cycle.
    bus.m_adr_i = {32'h0, 32'hA000_0000};
    bus.m_cyc_i = 2'b01;
    bus.m_stb_i = 2'b01;
    @(negedge clk);
    check("miss_grant", 32'(bus.grant_o), 32'd1);
    check("miss_s_stb", 32'(bus.s_stb_o), 32'd0);
    check("miss_s_cyc", 32'(bus.s_cyc_o), 32'd0);
    check("miss_noerr", 32'(bus.m_err_o), 32'd0);
    check("miss_dat", bus.m_dat_o, 32'd0);
    @(negedge clk);
    check("miss_err", 32'(bus.m_err_o), 32'd1);
    @(negedge clk);
    check("miss_gap", 32'(bus.m_err_o), 32'd0);
    @(negedge clk);
    check("miss_err2", 32'(bus.m_err_o), 32'd1);
    idle_all();
    @(negedge clk);
    check("miss_end", 32'(bus.m_err_o), 32'd0);

    // Silent slave 1: watchdog error after 15 stalled cycles, or never without the watchdog.
    bus.m_adr_i = {32'h0, 32'h9000_0000};
    bus.m_cyc_i = 2'b01;
    bus.m_stb_i = 2'b01;
    @(negedge clk);
    check("wd_s_stb", 32'(bus.s_stb_o), 32'h2);
    errs = 0;
    first = 0;
`ifdef WB_RR_INTERCON_WATCHDOG_EN
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (bus.m_err_o[0]) begin
        errs++;
        if (first == 0) first = i;
      end
    end
    check("wd_first", 32'(first), 32'd15);
    check("wd_count", 32'(errs), 32'd1);
`else
    for (int i = 1; i <= 1000; i++) begin
      @(negedge clk);
      if (bus.m_err_o[0]) errs++;
    end
    check("wd_none", 32'(errs), 32'd0);
`endif
    check("wd_stb_held", 32'(bus.s_stb_o), 32'h2);
    idle_all();
    @(negedge clk);

    // Asynchronous reset in the middle of a granted write.
    bus.m_adr_i = {32'h0, 32'h0000_0010};
    bus.m_dat_i = {32'h0, 32'h1234_5678};
    bus.m_sel_i = 8'h0F;
    bus.m_we_i  = 2'b01;
    bus.m_cyc_i = 2'b01;
    bus.m_stb_i = 2'b01;
    @(negedge clk);
    check("wr_grant", 32'(bus.grant_o), 32'd1);
    check("wr_we", 32'(bus.s_we_o), 32'd1);
    check("wr_dat", bus.s_dat_o, 32'h1234_5678);
    check("wr_sel", 32'(bus.s_sel_o), 32'hF);
    #1;
    rst_n = 1'b0;
    #1;
    check("ar_grant", 32'(bus.grant_o), 32'd0);
    check("ar_s_cyc", 32'(bus.s_cyc_o), 32'd0);
    check("ar_s_stb", 32'(bus.s_stb_o), 32'd0);
    check("ar_s_adr", bus.s_adr_o, 32'd0);
    check("ar_s_dat", bus.s_dat_o, 32'd0);
    check("ar_s_sel", 32'(bus.s_sel_o), 32'd0);
    check("ar_s_we", 32'(bus.s_we_o), 32'd0);
    check("ar_m_ack", 32'(bus.m_ack_o), 32'd0);
    check("ar_m_err", 32'(bus.m_err_o), 32'd0);
    bus.m_adr_i = {32'h0000_0010, 32'h0000_0010};
    bus.m_cyc_i = 2'b11;
    bus.m_stb_i = 2'b11;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("ar_prio0", 32'(bus.grant_o), 32'd1);
    idle_all();
    @(negedge clk);

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule
